// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing stages: default width,
// SNG state encoding and the maximal-length LFSR tap table.
package sc_pkg;

    localparam int SC_WIDTH_DEFAULT = 5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sng_state_t;

    // Tap mask for a left-shifting Fibonacci LFSR; bit i set means state[i] feeds
    // the XOR. The MSB is always a tap, which the de Bruijn zero-insertion relies on.
    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] taps;
        taps = '0;
        case (width)
            3:       taps = 32'b110;
            4:       taps = 32'b1100;
            5:       taps = 32'b10100;
            6:       taps = 32'b110000;
            7:       taps = 32'b1100000;
            8:       taps = 32'b10111000;
            9:       taps = 32'b100010000;
            10:      taps = 32'b1001000000;
            default: taps = '0;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/sc_debruijn_lfsr.sv
// Fibonacci LFSR extended with the all-zero state, so it walks all 2^WIDTH
// states before repeating.
module sc_debruijn_lfsr
    import sc_pkg::*;
#(
    parameter int               WIDTH = SC_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] state
);

    if (WIDTH < 3 || WIDTH > 10) begin : g_bad_width
        $error("sc_debruijn_lfsr: WIDTH must be within 3..10");
    end

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    logic [WIDTH-1:0] state_q, state_d;
    logic             feedback;

    // The zero-detect flips the feedback exactly at 100..0 -> 000..0 and 000..0 -> 000..1,
    // splicing the all-zero state into the maximal-length cycle.
    always_comb begin
        feedback = (^(state_q & TAPS)) ^ (state_q[WIDTH-2:0] == '0);
        state_d  = en ? {state_q[WIDTH-2:0], feedback} : state_q;
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking ones here
    // would race against every other flop reading state_q on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= SEED;
        else        state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/sc_number_generator.sv
// Stochastic number generator: emits a unipolar bitstream where every window of
// 2^WIDTH valid bits carries exactly `active` ones; new values swap in only at window edges.
module sc_number_generator
    import sc_pkg::*;
#(
    parameter int               WIDTH = SC_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH:0]   value_in,
    input  logic             value_valid,
    output logic             value_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             window_start
);

    if (WIDTH < 3 || WIDTH > 10) begin : g_bad_width
        $error("sc_number_generator: WIDTH must be within 3..10");
    end

    localparam logic [WIDTH:0] FULL = {1'b1, {WIDTH{1'b0}}};

    sng_state_t       state_q, state_d;
    logic [WIDTH-1:0] win_cnt_q, win_cnt_d;
    logic [WIDTH:0]   active_q, active_d;
    logic [WIDTH:0]   pending_q, pending_d;
    logic             pend_valid_q, pend_valid_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             window_start_q, window_start_d;

    logic [WIDTH-1:0] lfsr_state;
    logic             lfsr_en;
    logic             advance;
    logic             boundary;
    logic             accept;
    logic [WIDTH:0]   value_clamped;

    assign advance  = (state_q == RUN) && en;
    assign boundary = advance && (win_cnt_q == '1);
    assign lfsr_en  = advance;

    sc_debruijn_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (lfsr_en),
        .state (lfsr_state)
    );

    // NOTE: every always_comb output gets a default first, so no path can leave
    // a signal unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        win_cnt_d      = win_cnt_q;
        active_d       = active_q;
        pending_d      = pending_q;
        pend_valid_d   = pend_valid_q;
        bit_out_d      = bit_out_q;
        bit_valid_d    = 1'b0;
        window_start_d = 1'b0;

        value_clamped = (value_in > FULL) ? FULL : value_in;
        value_ready   = (state_q == IDLE) || !pend_valid_q;
        accept        = value_valid && value_ready;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    active_d  = value_clamped;
                    win_cnt_d = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (advance) begin
                    bit_out_d      = ({1'b0, lfsr_state} < active_q);
                    bit_valid_d    = 1'b1;
                    window_start_d = (win_cnt_q == '0);
                    win_cnt_d      = win_cnt_q + WIDTH'(1);
                end
                // A value arriving on the boundary with nothing pending skips the buffer.
                if (boundary && pend_valid_q) begin
                    active_d     = pending_q;
                    pend_valid_d = 1'b0;
                end else if (boundary && accept) begin
                    active_d = value_clamped;
                end else if (accept) begin
                    pending_d    = value_clamped;
                    pend_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            win_cnt_q      <= '0;
            active_q       <= '0;
            pending_q      <= '0;
            pend_valid_q   <= 1'b0;
            bit_out_q      <= 1'b0;
            bit_valid_q    <= 1'b0;
            window_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            win_cnt_q      <= win_cnt_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pend_valid_q   <= pend_valid_d;
            bit_out_q      <= bit_out_d;
            bit_valid_q    <= bit_valid_d;
            window_start_q <= window_start_d;
        end
    end

    assign bit_out      = bit_out_q;
    assign bit_valid    = bit_valid_q;
    assign window_start = window_start_q;

endmodule

// File: tb/tb_sc_number_generator.sv
// Directed bench for sc_number_generator (WIDTH=5, SEED=1): counts ones per
// window of valid bits and checks handshake timing around window boundaries.
module tb_sc_number_generator;
    import sc_pkg::*;

    localparam int W = 5;

    typedef struct {
        int ones;
        int nbits;
    } win_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         en = 1'b1;
    logic [W:0]   value_in = '0;
    logic         value_valid = 1'b0;
    logic         value_ready;
    logic         bit_out;
    logic         bit_valid;
    logic         window_start;

    logic         lfsr_en = 1'b0;
    logic [W-1:0] lfsr_state;

    int   checks = 0;
    int   errors = 0;
    win_t wins[$];
    bit   in_win = 1'b0;
    bit   rand_en = 1'b0;
    int   cur_ones = 0;
    int   cur_bits = 0;
    int   win_idx = 0;

    always #5 clk = ~clk;

    sc_number_generator #(.WIDTH(W), .SEED(5'b00001)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .value_in     (value_in),
        .value_valid  (value_valid),
        .value_ready  (value_ready),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid),
        .window_start (window_start)
    );

    sc_debruijn_lfsr #(.WIDTH(W), .SEED(5'b00001)) u_lfsr_ref (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (lfsr_en),
        .state (lfsr_state)
    );

    // One clock; outputs sampled 1 ns after the edge and tallied into windows.
    task automatic step();
        @(posedge clk);
        #1;
        if (!rst_n) begin
            in_win   = 1'b0;
            cur_ones = 0;
            cur_bits = 0;
        end else if (bit_valid) begin
            if (window_start) begin
                if (in_win) wins.push_back('{ones: cur_ones, nbits: cur_bits});
                in_win   = 1'b1;
                win_idx++;
                cur_ones = int'(bit_out);
                cur_bits = 1;
            end else if (in_win) begin
                cur_ones += int'(bit_out);
                cur_bits++;
            end
        end
        en = rand_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    endtask

    task automatic offer(input int v, input string tag);
        int budget;
        budget      = 0;
        value_in    = v[W:0];
        value_valid = 1'b1;
        while (!value_ready && budget < 200) begin
            step();
            budget++;
        end
        if (!value_ready) begin
            checks++;
            errors++;
            $display("FAIL %s: value %0d never accepted within 200 cycles", tag, v);
        end else begin
            step();
        end
        value_valid = 1'b0;
    endtask

    task automatic wait_windows(input int n, input string tag);
        int budget;
        budget = 0;
        while (wins.size() < n && budget < 3000) begin
            step();
            budget++;
        end
        if (wins.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s: only %0d of %0d windows completed", tag, wins.size(), n);
        end
    endtask

    task automatic wait_bits(input int k, input string tag);
        int budget;
        budget = 0;
        while (cur_bits != k && budget < 200) begin
            step();
            budget++;
        end
        if (cur_bits != k) begin
            checks++;
            errors++;
            $display("FAIL %s: window position %0d never reached", tag, k);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #10;
        checks++;
        if (bit_out !== 1'b0) begin errors++; $display("FAIL reset_bit_out: got %b expected 0", bit_out); end
        checks++;
        if (bit_valid !== 1'b0) begin errors++; $display("FAIL reset_bit_valid: got %b expected 0", bit_valid); end
        checks++;
        if (window_start !== 1'b0) begin errors++; $display("FAIL reset_window_start: got %b expected 0", window_start); end
        checks++;
        if (value_ready !== 1'b1) begin errors++; $display("FAIL reset_value_ready: got %b expected 1", value_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (bit_valid !== 1'b0) begin errors++; $display("FAIL idle_bit_valid: got %b expected 0", bit_valid); end
    endtask

    task automatic test_lfsr();
        logic [31:0] seen;
        seen = '0;
        checks++;
        if (lfsr_state !== 5'd1) begin errors++; $display("FAIL lfsr_seed: got %0d expected 1", lfsr_state); end
        lfsr_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            seen[lfsr_state] = 1'b1;
            step();
        end
        lfsr_en = 1'b0;
        checks++;
        if (seen !== 32'hFFFF_FFFF) begin errors++; $display("FAIL lfsr_distinct: visited mask %h expected ffffffff", seen); end
        checks++;
        if (lfsr_state !== 5'd1) begin errors++; $display("FAIL lfsr_period: got %0d expected 1", lfsr_state); end
        step();
        checks++;
        if (lfsr_state !== 5'd1) begin errors++; $display("FAIL lfsr_hold: got %0d expected 1", lfsr_state); end
    endtask

    task automatic test_values();
        int exp[4];
        exp = '{0, 32, 13, 32};
        wins.delete();
        offer(0, "values_load");
        checks++;
        if (bit_valid !== 1'b0) begin errors++; $display("FAIL latency_early: bit_valid=%b expected 0", bit_valid); end
        step();
        checks++;
        if (bit_valid !== 1'b1 || window_start !== 1'b1) begin
            errors++;
            $display("FAIL latency_first: bit_valid=%b window_start=%b expected 1 1", bit_valid, window_start);
        end
        offer(32, "values_32");
        offer(13, "values_13");
        offer(40, "values_40");
        wait_windows(4, "values");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= wins.size()) begin
                errors++;
                $display("FAIL values_win%0d: window missing", i);
            end else if (wins[i].ones !== exp[i] || wins[i].nbits !== 32) begin
                errors++;
                $display("FAIL values_win%0d: ones=%0d bits=%0d expected ones=%0d bits=32", i, wins[i].ones, wins[i].nbits, exp[i]);
            end
        end
    endtask

    task automatic test_pending_full();
        int exp[3];
        int low_cnt;
        exp = '{32, 20, 7};
        wins.delete();
        wait_bits(5, "pend_align");
        offer(20, "pend_20");
        value_in    = 6'd7;
        value_valid = 1'b1;
        low_cnt     = 0;
        while (!value_ready && low_cnt < 100) begin
            low_cnt++;
            step();
        end
        checks++;
        if (low_cnt !== 26 || cur_bits !== 32) begin
            errors++;
            $display("FAIL pend_ready_low: low for %0d cycles, freed at bit %0d; expected 26 and 32", low_cnt, cur_bits);
        end
        step();
        value_valid = 1'b0;
        wait_windows(3, "pend");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= wins.size()) begin
                errors++;
                $display("FAIL pend_win%0d: window missing", i);
            end else if (wins[i].ones !== exp[i] || wins[i].nbits !== 32) begin
                errors++;
                $display("FAIL pend_win%0d: ones=%0d bits=%0d expected ones=%0d bits=32", i, wins[i].ones, wins[i].nbits, exp[i]);
            end
        end
    endtask

    task automatic test_mid_window();
        int exp[3];
        int idx0;
        int budget;
        exp = '{7, 13, 20};
        wins.delete();
        offer(13, "mid_13");
        idx0   = win_idx;
        budget = 0;
        while (!(win_idx == idx0 + 1 && cur_bits == 10) && budget < 200) begin
            step();
            budget++;
        end
        offer(20, "mid_20");
        wait_windows(3, "mid");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= wins.size()) begin
                errors++;
                $display("FAIL mid_win%0d: window missing", i);
            end else if (wins[i].ones !== exp[i] || wins[i].nbits !== 32) begin
                errors++;
                $display("FAIL mid_win%0d: ones=%0d bits=%0d expected ones=%0d bits=32", i, wins[i].ones, wins[i].nbits, exp[i]);
            end
        end
    endtask

    task automatic test_bypass();
        int exp[2];
        exp = '{20, 25};
        wins.delete();
        wait_bits(31, "bypass_align");
        value_in    = 6'd25;
        value_valid = 1'b1;
        step();
        value_valid = 1'b0;
        checks++;
        if (value_ready !== 1'b1) begin errors++; $display("FAIL bypass_ready: got %b expected 1", value_ready); end
        wait_windows(2, "bypass");
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= wins.size()) begin
                errors++;
                $display("FAIL bypass_win%0d: window missing", i);
            end else if (wins[i].ones !== exp[i] || wins[i].nbits !== 32) begin
                errors++;
                $display("FAIL bypass_win%0d: ones=%0d bits=%0d expected ones=%0d bits=32", i, wins[i].ones, wins[i].nbits, exp[i]);
            end
        end
    endtask

    task automatic test_en_random();
        int exp[4];
        exp = '{25, 9, 9, 9};
        wins.delete();
        offer(9, "en_9");
        rand_en = 1'b1;
        wait_windows(4, "en_rand");
        rand_en = 1'b0;
        en      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= wins.size()) begin
                errors++;
                $display("FAIL en_win%0d: window missing", i);
            end else if (wins[i].ones !== exp[i] || wins[i].nbits !== 32) begin
                errors++;
                $display("FAIL en_win%0d: ones=%0d bits=%0d expected ones=%0d bits=32", i, wins[i].ones, wins[i].nbits, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        wait_bits(17, "rst_align");
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bit_out !== 1'b0 || bit_valid !== 1'b0 || window_start !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: bit_out=%b bit_valid=%b window_start=%b expected 0 0 0", bit_out, bit_valid, window_start);
        end
        checks++;
        if (dut.state_q !== IDLE || value_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_idle: state=%0d value_ready=%b expected 0 1", dut.state_q, value_ready);
        end
        in_win   = 1'b0;
        cur_ones = 0;
        cur_bits = 0;
        wins.delete();
        @(negedge clk);
        rst_n = 1'b1;
        offer(5, "rst_reload");
        checks++;
        if (bit_valid !== 1'b0) begin errors++; $display("FAIL rst_latency_early: bit_valid=%b expected 0", bit_valid); end
        step();
        checks++;
        if (bit_valid !== 1'b1 || window_start !== 1'b1) begin
            errors++;
            $display("FAIL rst_latency_first: bit_valid=%b window_start=%b expected 1 1", bit_valid, window_start);
        end
        wait_windows(1, "rst_reload");
        checks++;
        if (wins.size() < 1) begin
            errors++;
            $display("FAIL rst_win0: window missing");
        end else if (wins[0].ones !== 5 || wins[0].nbits !== 32) begin
            errors++;
            $display("FAIL rst_win0: ones=%0d bits=%0d expected ones=5 bits=32", wins[0].ones, wins[0].nbits);
        end
    endtask

    initial begin
        test_reset();
        test_lfsr();
        test_values();
        test_pending_full();
        test_mid_window();
        test_bypass();
        test_en_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
